// File: rtl/control_pipeline.sv
// Control-side pipeline: ID/EX, EX/MEM, MEM/WB control registers, hazard stall, branch/jump squash.
// Define CTRL_FWD_EN to enable ALU operand forwarding (load-use is then the only stall source).
module control_pipeline #(
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_reg_dst,
    input  logic                id_jump,
    input  logic                id_alu_src,
    input  logic                id_mem_to_reg,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_branch,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                ex_zero,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_flush,
    output logic                pc_src_branch,
    output logic                pc_src_jump,
    output logic                ex_alu_src,
    output logic                ex_reg_dst,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [REG_AW-1:0]   wb_dst,
    output logic [1:0]          forward_a,
    output logic [1:0]          forward_b
);

    typedef struct packed {
        logic                reg_dst, jump, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_AW-1:0]   rs, rt, rd;
    } id_ex_t;

    typedef struct packed {
        logic              mem_read, mem_write, mem_to_reg, reg_write;
        logic [REG_AW-1:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic              mem_to_reg, reg_write;
        logic [REG_AW-1:0] dst;
    } mem_wb_t;

    id_ex_t            id_ctrl, id_ex_q;
    ex_mem_t           ex_mem_q;
    mem_wb_t           mem_wb_q;
    logic [REG_AW-1:0] ex_dst;
    logic              id_uses_rt, taken, stall_req, stall;

    assign id_ctrl = {id_reg_dst, id_jump, id_alu_src, id_mem_to_reg, id_reg_write,
                      id_mem_read, id_mem_write, id_branch, id_alu_op, id_rs, id_rt, id_rd};

    assign ex_dst     = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;
    assign id_uses_rt = id_reg_dst | id_branch | id_mem_write;
    assign taken      = id_ex_q.branch & ex_zero;

`ifdef CTRL_FWD_EN
    logic load_use;
    logic unused_bits;

    assign load_use  = id_ex_q.mem_read & (id_ex_q.rt != '0) &
                       ((id_ex_q.rt == id_rs) | (id_uses_rt & (id_ex_q.rt == id_rt)));
    assign stall_req = load_use;
    // the stored jump bit only matters for the instruction's own squash in ID
    assign unused_bits = id_ex_q.jump;

    // EX/MEM is the younger producer, so it wins over MEM/WB
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (ex_mem_q.reg_write && ex_mem_q.dst != '0 && ex_mem_q.dst == id_ex_q.rs)
            forward_a = 2'b10;
        else if (mem_wb_q.reg_write && mem_wb_q.dst != '0 && mem_wb_q.dst == id_ex_q.rs)
            forward_a = 2'b01;
        if (ex_mem_q.reg_write && ex_mem_q.dst != '0 && ex_mem_q.dst == id_ex_q.rt)
            forward_b = 2'b10;
        else if (mem_wb_q.reg_write && mem_wb_q.dst != '0 && mem_wb_q.dst == id_ex_q.rt)
            forward_b = 2'b01;
    end
`else
    logic hit_ex, hit_mem;
    logic unused_bits;

    // MEM/WB is left out: the regfile writes in the first half-cycle
    assign hit_ex    = id_ex_q.reg_write & (ex_dst != '0) &
                       ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
    assign hit_mem   = ex_mem_q.reg_write & (ex_mem_q.dst != '0) &
                       ((ex_mem_q.dst == id_rs) | (id_uses_rt & (ex_mem_q.dst == id_rt)));
    assign stall_req = hit_ex | hit_mem;
    assign forward_a = 2'b00;
    assign forward_b = 2'b00;
    assign unused_bits = ^{id_ex_q.jump, id_ex_q.rs};
`endif

    // a taken branch squashes whatever sits in ID, so its hazard is moot
    assign stall         = stall_req & ~taken;
    assign pc_write      = ~stall;
    assign if_id_write   = ~stall;
    assign pc_src_branch = taken;
    assign pc_src_jump   = id_jump & ~taken & ~stall;
    assign if_id_flush   = taken | (id_jump & ~stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= (taken | stall) ? id_ex_t'('0) : id_ctrl;
            ex_mem_q <= {id_ex_q.mem_read, id_ex_q.mem_write, id_ex_q.mem_to_reg,
                         id_ex_q.reg_write, ex_dst};
            mem_wb_q <= {ex_mem_q.mem_to_reg, ex_mem_q.reg_write, ex_mem_q.dst};
        end
    end

    assign ex_alu_src    = id_ex_q.alu_src;
    assign ex_reg_dst    = id_ex_q.reg_dst;
    assign ex_alu_op     = id_ex_q.alu_op;
    assign mem_read      = ex_mem_q.mem_read;
    assign mem_write     = ex_mem_q.mem_write;
    assign wb_reg_write  = mem_wb_q.reg_write;
    assign wb_mem_to_reg = mem_wb_q.mem_to_reg;
    assign wb_dst        = mem_wb_q.dst;

endmodule
